// File: rtl/mopshub_uplink_frame_rx_if.sv
// Byte-stream input and assembled-frame output bundle of the uplink frame receiver.
// slave = receiver side, master = byte source / frame consumer.
interface mopshub_uplink_frame_rx_if;
    logic [7:0]  byte_in;
    logic        k_in;
    logic        byte_valid;
    logic [75:0] frame_out;
    logic        frame_valid;
    logic        frame_ack;
    logic        frame_err;
    logic [1:0]  err_code;
    logic        overflow;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;

    modport slave (
        input  byte_in, k_in, byte_valid, frame_ack,
        output frame_out, frame_valid, frame_err, err_code, overflow, frame_cnt, err_cnt
    );

    modport master (
        output byte_in, k_in, byte_valid, frame_ack,
        input  frame_out, frame_valid, frame_err, err_code, overflow, frame_cnt, err_cnt
    );
endinterface

// File: rtl/mopshub_uplink_frame_rx.sv
// Reassembles SOP / 10 data bytes / EOP elink frames into 76-bit CAN words
// with a one-deep holding register, error classification and frame counters.
module mopshub_uplink_frame_rx #(
    parameter logic [7:0]  SOP_K   = 8'h3C,
    parameter logic [7:0]  EOP_K   = 8'hDC,
    parameter logic [7:0]  IDLE_K  = 8'hBC,
    parameter int unsigned N_BYTES = 10
) (
    input  logic                       clk,
    input  logic                       rst,
    mopshub_uplink_frame_rx_if.slave   bus
);
    localparam int unsigned FRAME_W = 76;
    localparam int unsigned ASM_W   = 8 * N_BYTES;
    localparam int unsigned IDX_W   = $clog2(N_BYTES + 1);

    localparam logic [1:0] ERR_SHORT = 2'd1;
    localparam logic [1:0] ERR_LONG  = 2'd2;
    localparam logic [1:0] ERR_PAD   = 2'd3;

    typedef enum logic [1:0] {IDLE, DATA, WAIT_EOP} state_t;

    state_t             state;
    logic [IDX_W-1:0]   idx;
    logic [ASM_W-1:0]   assembly;

    logic       is_sop_c, is_eop_c, is_idle_c;
    logic       err_c, good_c;
    logic [1:0] code_c;

    assign is_sop_c  = bus.k_in && (bus.byte_in == SOP_K);
    assign is_eop_c  = bus.k_in && (bus.byte_in == EOP_K);
    assign is_idle_c = bus.k_in && (bus.byte_in == IDLE_K);

    // Error / completion classification of the byte consumed this cycle
    always_comb begin
        err_c  = 1'b0;
        good_c = 1'b0;
        code_c = 2'd0;
        if (bus.byte_valid) begin
            unique case (state)
                DATA: begin
                    if (bus.k_in && !is_idle_c) begin
                        err_c  = 1'b1;
                        code_c = ERR_SHORT;
                    end
                end
                WAIT_EOP: begin
                    if (is_eop_c) begin
                        if (assembly[ASM_W-1:FRAME_W] != '0) begin
                            err_c  = 1'b1;
                            code_c = ERR_PAD;
                        end else begin
                            good_c = 1'b1;
                        end
                    end else if (!is_idle_c) begin
                        err_c  = 1'b1;
                        code_c = ERR_LONG;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state           <= IDLE;
            idx             <= '0;
            assembly        <= '0;
            bus.frame_out   <= '0;
            bus.frame_valid <= 1'b0;
            bus.frame_err   <= 1'b0;
            bus.err_code    <= 2'd0;
            bus.overflow    <= 1'b0;
            bus.frame_cnt   <= 16'd0;
            bus.err_cnt     <= 8'd0;
        end else begin
            bus.frame_err <= err_c;
            if (err_c) begin
                bus.err_code <= code_c;
                if (bus.err_cnt != 8'hFF) bus.err_cnt <= bus.err_cnt + 8'd1;
            end

            if (bus.frame_valid && bus.frame_ack) bus.frame_valid <= 1'b0;

            // A same-cycle ack frees the holding register for the new frame
            if (good_c) begin
                if (!bus.frame_valid || bus.frame_ack) begin
                    bus.frame_out   <= assembly[FRAME_W-1:0];
                    bus.frame_valid <= 1'b1;
                    bus.frame_cnt   <= bus.frame_cnt + 16'd1;
                end else begin
                    bus.overflow <= 1'b1;
                end
            end

            if (bus.byte_valid) begin
                unique case (state)
                    IDLE: begin
                        if (is_sop_c) begin
                            state <= DATA;
                            idx   <= '0;
                        end
                    end
                    DATA: begin
                        if (!bus.k_in) begin
                            assembly <= {assembly[ASM_W-9:0], bus.byte_in};
                            idx      <= idx + IDX_W'(1);
                            if (idx == IDX_W'(N_BYTES - 1)) state <= WAIT_EOP;
                        end else if (is_sop_c) begin
                            idx <= '0;
                        end else if (!is_idle_c) begin
                            state <= IDLE;
                        end
                    end
                    WAIT_EOP: begin
                        if (is_sop_c) begin
                            state <= DATA;
                            idx   <= '0;
                        end else if (!is_idle_c) begin
                            state <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_mopshub_uplink_frame_rx.sv
// Directed plus randomized bench for mopshub_uplink_frame_rx against a
// queue-based frame model.
module tb_mopshub_uplink_frame_rx;
    localparam logic [7:0] SOP  = 8'h3C;
    localparam logic [7:0] EOP  = 8'hDC;
    localparam logic [7:0] IDLK = 8'hBC;
    localparam logic [7:0] BADK = 8'hFC;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    mopshub_uplink_frame_rx_if bus();

    mopshub_uplink_frame_rx dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [7:0]  q[$];
    bit          active;
    logic        m_valid;
    logic [75:0] m_out;
    logic        m_err;
    logic [1:0]  m_code;
    logic        m_ovf;
    logic [15:0] m_cnt;
    logic [7:0]  m_ecnt;

    bit rand_ack;
    bit rand_gap;

    task automatic chk(input string tag, input logic [75:0] obs, input logic [75:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        q.delete();
        active  = 1'b0;
        m_valid = 1'b0;
        m_out   = '0;
        m_err   = 1'b0;
        m_code  = 2'd0;
        m_ovf   = 1'b0;
        m_cnt   = 16'd0;
        m_ecnt  = 8'd0;
    endtask

    task automatic model_step(input logic bv, input logic [7:0] b, input logic k, input logic ack);
        bit e = 0;
        bit good = 0;
        logic [1:0] code = 2'd0;
        logic [79:0] f = '0;
        bit was_valid = m_valid;
        if (bv) begin
            if (!active) begin
                if (k && b == SOP) begin active = 1; q.delete(); end
            end else if (k && b == IDLK) begin
            end else if (q.size() < 10) begin
                if (!k) q.push_back(b);
                else begin
                    e = 1; code = 2'd1;
                    if (b == SOP) q.delete(); else active = 0;
                end
            end else begin
                if (k && b == EOP) begin
                    active = 0;
                    if (q[0][7:4] != 4'h0) begin e = 1; code = 2'd3; end
                    else good = 1;
                end else begin
                    e = 1; code = 2'd2;
                    if (k && b == SOP) q.delete(); else active = 0;
                end
            end
        end
        m_err = e;
        if (e) begin
            m_code = code;
            if (m_ecnt < 8'd255) m_ecnt = m_ecnt + 8'd1;
        end
        if (was_valid && ack) m_valid = 0;
        if (good) begin
            if (!was_valid || ack) begin
                foreach (q[i]) f = f * 256 + 80'(q[i]);
                m_out   = f[75:0];
                m_valid = 1;
                m_cnt   = m_cnt + 16'd1;
            end else m_ovf = 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".frame_valid"}, 76'(bus.frame_valid), 76'(m_valid));
        chk({tag, ".frame_out"},   bus.frame_out,         m_out);
        chk({tag, ".frame_err"},   76'(bus.frame_err),   76'(m_err));
        chk({tag, ".err_code"},    76'(bus.err_code),    76'(m_code));
        chk({tag, ".overflow"},    76'(bus.overflow),    76'(m_ovf));
        chk({tag, ".frame_cnt"},   76'(bus.frame_cnt),   76'(m_cnt));
        chk({tag, ".err_cnt"},     76'(bus.err_cnt),     76'(m_ecnt));
    endtask

    task automatic step(input logic bv, input logic [7:0] b, input logic k, input logic ack);
        bus.byte_valid = bv;
        bus.byte_in    = b;
        bus.k_in       = k;
        bus.frame_ack  = ack;
        model_step(bv, b, k, ack);
        @(posedge clk);
        #1;
        check_all("step");
    endtask

    function automatic logic pick_ack();
        return rand_ack && ($urandom_range(0, 2) == 0);
    endfunction

    task automatic send(input logic [7:0] b, input logic k);
        if (rand_gap && $urandom_range(0, 4) == 0)
            step(1'b0, 8'($urandom), 1'($urandom), pick_ack());
        if (rand_gap && $urandom_range(0, 7) == 0)
            step(1'b1, IDLK, 1'b1, pick_ack());
        step(1'b1, b, k, pick_ack());
    endtask

    task automatic send_frame(input logic [7:0] first, input int n);
        send(SOP, 1'b1);
        for (int i = 0; i < n; i++) send(i == 0 ? first : 8'($urandom), 1'b0);
    endtask

    task automatic do_reset(input string tag);
        rst = 1'b0;
        #1;
        model_reset();
        check_all(tag);
        #2;
        rst = 1'b1;
    endtask

    initial begin
        bus.byte_valid = 1'b0;
        bus.byte_in    = 8'h00;
        bus.k_in       = 1'b0;
        bus.frame_ack  = 1'b0;
        rand_ack = 0;
        rand_gap = 0;
        model_reset();
        #1;
        check_all("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;

        // Single frame 00..09, no ack
        step(1, SOP, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 8'(i), 0, 0);
        step(1, EOP, 1, 0);
        chk("single.valid", 76'(bus.frame_valid), 76'd1);
        chk("single.out", bus.frame_out, 76'h0_0102_0304_0506_0708_09);
        chk("single.cnt", 76'(bus.frame_cnt), 76'd1);
        chk("single.err", 76'(bus.frame_err), 76'd0);

        // Second good frame while held -> dropped
        step(1, SOP, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 8'(i + 5), 0, 0);
        step(1, EOP, 1, 0);
        chk("ovf.flag", 76'(bus.overflow), 76'd1);
        chk("ovf.out", bus.frame_out, 76'h0_0102_0304_0506_0708_09);
        chk("ovf.cnt", 76'(bus.frame_cnt), 76'd1);
        chk("ovf.err", 76'(bus.frame_err), 76'd0);

        // Same-cycle ack on EOP loads the new frame
        step(1, SOP, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 8'(i + 10), 0, 0);
        step(1, EOP, 1, 1);
        chk("ack.valid", 76'(bus.frame_valid), 76'd1);
        chk("ack.out", bus.frame_out, 76'hA0B0C0D0E0F10111213);
        chk("ack.cnt", 76'(bus.frame_cnt), 76'd2);
        step(0, 8'h00, 0, 1);
        chk("ack.clear", 76'(bus.frame_valid), 76'd0);

        // Short frame
        step(1, SOP, 1, 0);
        for (int i = 0; i < 5; i++) step(1, 8'(i), 0, 0);
        step(1, EOP, 1, 0);
        chk("short.err", 76'(bus.frame_err), 76'd1);
        chk("short.code", 76'(bus.err_code), 76'd1);
        chk("short.ecnt", 76'(bus.err_cnt), 76'd1);
        chk("short.valid", 76'(bus.frame_valid), 76'd0);
        step(0, 8'h00, 0, 0);
        chk("short.pulse", 76'(bus.frame_err), 76'd0);

        // Long frame: 11th data byte
        step(1, SOP, 1, 0);
        for (int i = 0; i < 11; i++) step(1, 8'(i), 0, 0);
        chk("long.code", 76'(bus.err_code), 76'd2);
        chk("long.ecnt", 76'(bus.err_cnt), 76'd2);
        step(1, EOP, 1, 0);

        // Pad error
        step(1, SOP, 1, 0);
        step(1, 8'h10, 0, 0);
        for (int i = 1; i < 10; i++) step(1, 8'(i), 0, 0);
        step(1, EOP, 1, 0);
        chk("pad.code", 76'(bus.err_code), 76'd3);
        chk("pad.cnt", 76'(bus.frame_cnt), 76'd2);
        chk("pad.valid", 76'(bus.frame_valid), 76'd0);

        // IDLE_K fill inside a frame
        step(1, SOP, 1, 0);
        for (int i = 0; i < 10; i++) begin
            step(1, 8'(i), 0, 0);
            if (i % 3 == 1) step(1, IDLK, 1, 0);
        end
        step(1, EOP, 1, 0);
        chk("fill.out", bus.frame_out, 76'h0_0102_0304_0506_0708_09);
        chk("fill.cnt", 76'(bus.frame_cnt), 76'd3);

        // Reset mid-frame, then a clean frame
        step(1, SOP, 1, 0);
        for (int i = 0; i < 4; i++) step(1, 8'hA0 + 8'(i), 0, 0);
        do_reset("midrst");
        chk("midrst.ovf", 76'(bus.overflow), 76'd0);
        step(1, SOP, 1, 0);
        for (int i = 0; i < 10; i++) step(1, 8'(i), 0, 0);
        step(1, EOP, 1, 0);
        chk("post.out", bus.frame_out, 76'h0_0102_0304_0506_0708_09);
        chk("post.cnt", 76'(bus.frame_cnt), 76'd1);

        // Randomized traffic
        rand_ack = 1;
        rand_gap = 1;
        for (int n = 0; n < 60; n++) begin
            int kind = $urandom_range(0, 11);
            logic [7:0] first = 8'($urandom_range(0, 15));
            case (kind)
                0: begin send_frame(first, $urandom_range(0, 9)); send(EOP, 1); end
                1: begin send_frame(first, 11); send(EOP, 1); end
                2: begin send_frame(8'h80 | first, 10); send(EOP, 1); end
                3: begin send_frame(first, $urandom_range(1, 9)); send(BADK, 1); end
                4: begin send_frame(first, 10); send(8'($urandom), 1'($urandom)); end
                5: begin send_frame(first, $urandom_range(0, 10)); end
                default: begin send_frame(first, 10); send(EOP, 1); end
            endcase
            if ($urandom_range(0, 3) == 0) send(BADK, 1);
            if ($urandom_range(0, 3) == 0) send(8'($urandom), 0);
        end
        for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
